uart_tx_serializer: RTL and testbench

- Downstream consumer of the single-entry TX FIFO in the UART transmit path.
- Pops one byte when the FIFO reports not-empty and serializes it as 8N1 on the TX pin: start bit 0, 8 data bits LSB first, stop bit 1.
- Provides frame status (active, done) to the top level and LEDs.

---
 rtl/uart_tx_serializer.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the single-entry TX FIFO and sends each
// as an 8N1 frame (start 0, 8 data bits LSB first, stop 1).
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a parity bit is inserted between the data and the stop bit
//                (even parity, or odd when PARITY_ODD=1); frame is 11 bits
//   undefined -> plain 8N1, no parity state or register; PARITY_ODD is ignored
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (>= 2)
//   PARITY_ODD    parity sense when parity is enabled (0 even, 1 odd)
//
// Ports:
//   i_clk             system clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_fifo_not_empty  FIFO holds a byte; i_fifo_data valid while high
//   i_fifo_data       byte at FIFO head
//   o_fifo_rd_en      registered one-cycle pop strobe
//   o_tx_serial       registered serial line, idles high
//   o_tx_active       high while a frame is on the line
//   o_tx_done         one-cycle pulse on the last cycle of the stop bit

module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_fifo_not_empty,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_rd_en,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    // Elaboration-time parameter legality
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                rd_en_q, rd_en_d;
    logic                serial_q, serial_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
    logic                bit_end;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_INV = (PARITY_ODD != 0);
    logic                parity_q, parity_d;
`endif

    assign bit_end = (clk_cnt_q == CNT_LAST);

    // Next-state, datapath and output computation
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rd_en_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (i_fifo_not_empty) begin
                    // Byte is captured here; the pop lands the following cycle
                    shift_d = i_fifo_data;
                    rd_en_d = 1'b1;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^i_fifo_data) ^ PAR_INV;
`endif
                end
            end

            S_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q
        serial_d = 1'b1;
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: serial_d = parity_d;
`endif
            default:  serial_d = 1'b1;
        endcase
        active_d = (state_d != S_IDLE);
        done_d   = (state_d == S_STOP) && (clk_cnt_d == CNT_LAST);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rd_en_q   <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rd_en_q   <= rd_en_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_fifo_rd_en = rd_en_q;
    assign o_tx_serial  = serial_q;
    assign o_tx_active  = active_q;
    assign o_tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer with CLKS_PER_BIT=4 and a single-entry FIFO model.

module tb_uart_tx_serializer;

    localparam int unsigned N          = 4;
    localparam int unsigned PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned FRAME_CYC = FB * N;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       o_fifo_rd_en, o_tx_serial, o_tx_active, o_tx_done;

    // Single-entry FIFO model
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_q = 8'h00;

    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         frames_seen = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLKS_PER_BIT (N),
        .PARITY_ODD   (PARITY_ODD)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_fifo_not_empty (fifo_full),
        .i_fifo_data      (fifo_q),
        .o_fifo_rd_en     (o_fifo_rd_en),
        .o_tx_serial      (o_tx_serial),
        .o_tx_active      (o_tx_active),
        .o_tx_done        (o_tx_done)
    );

    always @(posedge clk) begin
        if (wr_req) begin
            fifo_full <= 1'b1;
            fifo_q    <= wr_data;
        end else if (o_fifo_rd_en) begin
            fifo_full <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
        end
    endtask

    task automatic report(input string name, input int nerr, input int cyc,
                          input logic got, input logic exp);
        total++;
        if (nerr != 0) begin
            bad++;
            $display("FAIL %s: %0d cycles wrong, first at frame cycle %0d got %0b want %0b",
                     name, nerr, cyc, got, exp);
        end
    endtask

    // Expected line level for frame bit idx, given {stop,data,start} and parity
    function automatic logic exp_bit(input logic [9:0] line, input logic par, input int idx);
`ifdef UART_TX_PARITY_EN
        if (idx < 9) return line[idx];
        if (idx == 9) return par;
        return line[9];
`else
        return line[idx];
`endif
    endfunction

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    task automatic wait_start(input string name, output bit found, output int w);
        found = 1'b0;
        w = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            w++;
            if (o_tx_serial == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s_start_timeout: line stayed %0b, want 0 within 400 cycles", name, o_tx_serial);
        end
    endtask

    // Checks one whole frame cycle by cycle, starting at its first start-bit cycle
    task automatic check_frame(input string name, input logic [9:0] line, input logic par_even,
                               input bit immediate, input bit mid_wr, input logic [7:0] mid_data);
        bit   found;
        int   w;
        logic par, es;
        int   nl, na, nd, nr, fl, fa, fd, fr;
        logic gl, xl, ga, gd, xd, gr, xr;
        nl = 0; na = 0; nd = 0; nr = 0;
        fl = 0; fa = 0; fd = 0; fr = 0;
        gl = 0; xl = 0; ga = 0; gd = 0; xd = 0; gr = 0; xr = 0;
        par = par_even ^ 1'(PARITY_ODD);
        wait_start(name, found, w);
        if (!found) return;
        if (immediate) chk({name, "_b2b_idle_cycles"}, w, 1);
        for (int c = 1; c <= int'(FRAME_CYC); c++) begin
            if (c > 1) @(negedge clk);
            if (mid_wr && c == 8) begin
                wr_req  = 1'b1;
                wr_data = mid_data;
                exp_q.push_back(mid_data);
            end
            if (mid_wr && c == 9) wr_req = 1'b0;
            es = exp_bit(line, par, (c - 1) / int'(N));
            if (o_tx_serial !== es) begin
                if (nl == 0) begin fl = c; gl = o_tx_serial; xl = es; end
                nl++;
            end
            if (o_tx_active !== 1'b1) begin
                if (na == 0) begin fa = c; ga = o_tx_active; end
                na++;
            end
            if (o_tx_done !== (c == int'(FRAME_CYC))) begin
                if (nd == 0) begin fd = c; gd = o_tx_done; xd = (c == int'(FRAME_CYC)); end
                nd++;
            end
            if (o_fifo_rd_en !== (c == 1)) begin
                if (nr == 0) begin fr = c; gr = o_fifo_rd_en; xr = (c == 1); end
                nr++;
            end
        end
        report({name, "_line"}, nl, fl, gl, xl);
        report({name, "_active"}, na, fa, ga, 1'b1);
        report({name, "_done"}, nd, fd, gd, xd);
        report({name, "_rd_en"}, nr, fr, gr, xr);
        @(negedge clk);
        chk({name, "_post_frame"}, {o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en}, 4'b1000);
    endtask

    // Scoreboard monitor: decodes frames mid-bit and compares against queued bytes
    initial begin : monitor
        logic [10:0] bits;
        logic [10:0] want;
        logic [7:0]  e;
        bit          abort;
        forever begin
            @(negedge clk);
            if (rst_n && o_tx_serial == 1'b0) begin
                bits  = '0;
                abort = 1'b0;
                for (int c = 1; c <= int'(FRAME_CYC); c++) begin
                    if (c > 1) @(negedge clk);
                    if (!rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    if ((c % int'(N)) == int'(N / 2)) bits[c / int'(N)] = o_tx_serial;
                end
                if (!abort) begin
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected_frame: got bits 0x%0h want no frame", bits);
                    end else begin
                        e = exp_q.pop_front();
                        want = '0;
                        for (int i = 0; i < int'(FB); i++)
                            want[i] = exp_bit({1'b1, e, 1'b0}, (^e) ^ 1'(PARITY_ODD), i);
                        chk("sb_frame", 32'(bits), 32'(want));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        logic       par_even;
    } vec_t;

    initial begin : main
        vec_t vecs[5];
        int   errs;
        bit   found;
        int   w;

        vecs[0] = '{data: 8'h55, line: 10'b1_01010101_0, par_even: 1'b0};
        vecs[1] = '{data: 8'h00, line: 10'b1_00000000_0, par_even: 1'b0};
        vecs[2] = '{data: 8'hFF, line: 10'b1_11111111_0, par_even: 1'b0};
        vecs[3] = '{data: 8'h01, line: 10'b1_00000001_0, par_even: 1'b1};
        vecs[4] = '{data: 8'h07, line: 10'b1_00000111_0, par_even: 1'b1};

        // Held in reset with FIFO empty
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en} !== 4'b1000) errs++;
        end
        chk("reset_outputs_errs", errs, 0);
        rst_n = 1'b1;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en} !== 4'b1000) errs++;
        end
        chk("idle_empty_errs", errs, 0);

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            push_byte(vecs[v].data);
            check_frame($sformatf("vec%0d_%02h", v, vecs[v].data), vecs[v].line,
                        vecs[v].par_even, 1'b0, 1'b0, 8'h00);
        end

        // FIFO refilled mid-frame: first byte unchanged, second sent after one idle cycle
        push_byte(8'h81);
        check_frame("hold_81", 10'b1_10000001_0, 1'b0, 1'b0, 1'b1, 8'h3C);
        check_frame("next_3c", 10'b1_00111100_0, 1'b0, 1'b1, 1'b0, 8'h00);

        // Reset in the middle of the data bits
        push_byte(8'hA3);
        wait_start("rst_a3", found, w);
        if (found) begin
            repeat (17) @(negedge clk);
            chk("rst_a3_line_before", 32'(o_tx_serial), 32'(1'b0));
            #2 rst_n = 1'b0;
            #1 chk("rst_a3_async", {o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en}, 4'b1000);
            void'(exp_q.pop_front());
            errs = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if ({o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en} !== 4'b1000) errs++;
            end
            rst_n = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if ({o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en} !== 4'b1000) errs++;
            end
            chk("rst_a3_idle_after_errs", errs, 0);
        end

        // Reset during the pop strobe: byte stays in the FIFO and is sent afterwards
        push_byte(8'h5A);
        wait_start("strobe_5a", found, w);
        if (found) begin
            chk("strobe_5a_rd_en", 32'(o_fifo_rd_en), 32'(1'b1));
            #2 rst_n = 1'b0;
            #1 chk("strobe_5a_cut", {o_tx_serial, o_tx_active, o_tx_done, o_fifo_rd_en}, 4'b1000);
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            check_frame("strobe_5a_resend", 10'b1_01011010_0, 1'b0, 1'b0, 1'b0, 8'h00);
        end

        repeat (10) @(negedge clk);
        chk("sb_queue_left", exp_q.size(), 0);
        chk("sb_frames_seen", frames_seen, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
